sprocket_cds_accum: RTL and testbench
=====================================

SPROCKET_CDS_ACCUM -- requirements
Module: sprocket_cds_accum

Interface
REQ-001 SHALL have parameter PIXEL_CLUSTER_SIZE, default 16, meaning pixels per cluster readout.
REQ-002 SHALL have parameter ADC_WIDTH, default 12, meaning unsigned ADC code width.
REQ-003 SHALL have parameter ACC_WIDTH, default 24, meaning signed accumulator/result width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port skip_samples  in  10  CDS samples per pixel; 0 is treated as 1.
REQ-007 SHALL have port sprocket_phi1  in  1  pedestal sample strobe from the pattern sequencer (level).
REQ-008 SHALL have port sprocket_phi2  in  1  signal sample strobe from the pattern sequencer (level).
REQ-009 SHALL have port sprocket_eoc  out  1  end-of-conversion flag returned to the sequencer.
REQ-010 SHALL have port adc_start  out  1  one-cycle conversion start pulse to the ADC.
REQ-011 SHALL have port adc_done  in  1  one-cycle pulse; adc_data is valid in the same cycle.
REQ-012 SHALL have port adc_data  in  ADC_WIDTH  conversion result.
REQ-013 SHALL have port pix_data  out  ACC_WIDTH  signed accumulated CDS sum for one pixel.
REQ-014 SHALL have port pix_index  out  $clog2(PIXEL_CLUSTER_SIZE)  pixel number of pix_data.
REQ-015 SHALL have port pix_valid / pix_ready  out / in  1  valid/ready output handshake.
REQ-016 SHALL have port status  out  3  sticky {overflow, overrun, seq_err}.

Function
REQ-017 SHALL detect rising edges of phi1/phi2 with one-cycle registered edge detection; high levels alone SHALL NOT trigger.
REQ-018 SHALL implement FSM: IDLE -> (phi1 edge) CONV_PED -> (adc_done) WAIT_SIG -> (phi2 edge) CONV_SIG -> (adc_done) ACCUM -> WAIT_PED or EMIT -> WAIT_PED/IDLE.
REQ-019 SHALL pulse adc_start for one cycle, in the cycle after the qualifying phi edge.
REQ-020 SHALL latch pedestal on adc_done in CONV_PED; in CONV_SIG, cds = pedestal - signal as ADC_WIDTH+1-bit signed.
REQ-021 SHALL sign-extend cds and add to the accumulator in ACCUM (one cycle); skip counter increments.
REQ-022 SHALL go from ACCUM to EMIT when skip count reaches max(skip_samples,1), else to WAIT_PED.
REQ-023 SHALL, in EMIT, load pix_data/pix_index, assert pix_valid, clear accumulator and skip count, increment pixel index (wrap PIXEL_CLUSTER_SIZE-1 -> 0, then IDLE).
REQ-024 SHALL hold pix_data/pix_index stable while pix_valid && !pix_ready; drop pix_valid the cycle after the handshake.
REQ-025 SHALL, when EMIT occurs with pix_valid still high, overwrite the output and set overrun.
REQ-026 SHALL set sprocket_eoc the cycle after each adc_done and clear it on the next phi1 or phi2 rising edge.
REQ-027 SHALL ignore phi edges in CONV_PED/CONV_SIG/ACCUM, phi2 edges in IDLE/WAIT_PED, and phi1 edges in WAIT_SIG, setting seq_err for each.
REQ-028 SHALL give a phi edge priority over nothing else: phi1 and phi2 edges in the same cycle set seq_err and are both ignored.
REQ-029 SHALL sample skip_samples only at pixel start (first phi1 edge of a pixel).

Reset
REQ-030 SHALL, on reset_n low, force IDLE, clear accumulator, counters, pix_data, pix_index, pix_valid, adc_start, sprocket_eoc, and status to 0 immediately.
REQ-031 SHALL, on reset mid-conversion, discard the pending adc_done if it arrives after release while in IDLE.

Configuration
REQ-032 SHALL support macro CDS_SATURATE_EN: when defined, the accumulator clamps to the signed ACC_WIDTH max/min and sets overflow.
REQ-033 SHALL, when CDS_SATURATE_EN is undefined, wrap modulo 2^ACC_WIDTH and still set overflow on signed overflow.

Structure
REQ-034 SHALL place the FSM state enum, status bit indices, and default widths in package sprocket_pkg.
REQ-035 SHALL use one sub-module, sprocket_edge_det, instantiated for phi1 and phi2.

Verification
REQ-036 SHALL cover: skip_samples=10, ped=2000, sig=1900 for all 16 pixels -> 16 pix_valid with pix_data=1000, pix_index 0..15, then IDLE.
REQ-037 SHALL cover: skip_samples=0, ped=100, sig=300 -> pix_data=-200 after one pedestal/signal pair.
REQ-038 SHALL cover: pix_ready held low across two pixels -> overrun=1, pix_data equals the second pixel's sum.
REQ-039 SHALL cover: phi2 edge in IDLE, then phi1 edge during CONV_PED -> seq_err=1, no extra adc_start, final sum unaffected.
REQ-040 SHALL cover: ACC_WIDTH=14, ped=4095, sig=0, skip_samples=10 -> overflow=1; pix_data=8191 with CDS_SATURATE_EN, wrapped value without it.
REQ-041 SHALL cover: reset_n low for 3 cycles during CONV_SIG -> all outputs 0 immediately, late adc_done ignored, and next pixel_index=0.

Source files
------------

// File: rtl/sprocket_pkg.sv
// ============================================================================
// Module      : sprocket_pkg
// Description : Shared definitions for the sprocket CDS accumulator: default
//               widths, status bit positions and the sequencing FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprocket_pkg;

    localparam int DEF_PIXEL_CLUSTER_SIZE = 16;
    localparam int DEF_ADC_WIDTH          = 12;
    localparam int DEF_ACC_WIDTH          = 24;
    localparam int SKIP_WIDTH             = 10;
    localparam int STATUS_WIDTH           = 3;

    // status = {overflow, overrun, seq_err}
    localparam int STAT_SEQ_ERR  = 0;
    localparam int STAT_OVERRUN  = 1;
    localparam int STAT_OVERFLOW = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONV_PED = 3'd1,
        ST_WAIT_SIG = 3'd2,
        ST_CONV_SIG = 3'd3,
        ST_ACCUM    = 3'd4,
        ST_EMIT     = 3'd5,
        ST_WAIT_PED = 3'd6
    } cds_state_e;

endpackage

`default_nettype wire

// File: rtl/sprocket_edge_det.sv
// ============================================================================
// Module      : sprocket_edge_det
// Description : Registered rising-edge detector for a sequencer strobe level.
//               rise_o is a single-cycle pulse one cycle after the level is
//               first sampled high; a held-high level produces no further
//               pulses.
// Ports       : clk, reset_n  - clock, asynchronous active-low reset
//               level_i       - strobe level
//               rise_o        - registered rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprocket_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= level_i;
            rise_q <= level_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/sprocket_cds_accum.sv
// ============================================================================
// Module      : sprocket_cds_accum
// Description : Correlated double sampling accumulator. For each pixel, a
//               pedestal (phi1) and signal (phi2) conversion are requested
//               from the ADC; cds = pedestal - signal is summed over
//               max(skip_samples,1) pairs and the per-pixel sum is presented
//               on a valid/ready output.
// Config      : CDS_SATURATE_EN - when defined the accumulator clamps at the
//               signed ACC_WIDTH limits; otherwise it wraps. Overflow is
//               flagged in status either way.
// Ports       : clk, reset_n            - clock, async active-low reset
//               skip_samples           - CDS pairs per pixel (0 means 1)
//               sprocket_phi1/phi2     - pedestal/signal strobes (levels)
//               sprocket_eoc           - end-of-conversion flag
//               adc_start/done/data    - ADC handshake
//               pix_data/index/valid/ready - pixel result stream
//               status                 - sticky {overflow, overrun, seq_err}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprocket_cds_accum
    import sprocket_pkg::*;
#(
    parameter int PIXEL_CLUSTER_SIZE = DEF_PIXEL_CLUSTER_SIZE,
    parameter int ADC_WIDTH          = DEF_ADC_WIDTH,
    parameter int ACC_WIDTH          = DEF_ACC_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [SKIP_WIDTH-1:0]                 skip_samples,
    input  logic                                  sprocket_phi1,
    input  logic                                  sprocket_phi2,
    output logic                                  sprocket_eoc,
    output logic                                  adc_start,
    input  logic                                  adc_done,
    input  logic [ADC_WIDTH-1:0]                  adc_data,
    output logic [ACC_WIDTH-1:0]                  pix_data,
    output logic [$clog2(PIXEL_CLUSTER_SIZE)-1:0] pix_index,
    output logic                                  pix_valid,
    input  logic                                  pix_ready,
    output logic [STATUS_WIDTH-1:0]               status
);

    localparam int IDX_W = $clog2(PIXEL_CLUSTER_SIZE);
    localparam int CDS_W = ADC_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_CLUSTER_SIZE - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    cds_state_e                  state_q, state_d;
    logic [ADC_WIDTH-1:0]        ped_q;
    logic signed [CDS_W-1:0]     cds_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [SKIP_WIDTH-1:0]       skip_cnt_q;
    logic [SKIP_WIDTH-1:0]       skip_max_q;
    logic [IDX_W-1:0]            pix_cnt_q;

    logic                        adc_start_q, adc_start_d;
    logic                        eoc_q, eoc_d;
    logic [ACC_WIDTH-1:0]        pix_data_q, pix_data_d;
    logic [IDX_W-1:0]            pix_index_q, pix_index_d;
    logic                        pix_valid_q, pix_valid_d;
    logic [STATUS_WIDTH-1:0]     status_q, status_d;

    logic w_phi1_rise, w_phi2_rise;
    logic w_phi1_ok, w_phi2_ok, w_seq_err, w_conv_done;
    logic [SKIP_WIDTH:0] w_cnt_inc;
    logic w_last_sample;
    logic signed [ACC_WIDTH-1:0] w_cds_ext, w_sum, w_acc_next;
    logic w_ovf;

    sprocket_edge_det u_edge_phi1 (
        .clk     (clk),
        .reset_n (reset_n),
        .level_i (sprocket_phi1),
        .rise_o  (w_phi1_rise)
    );

    sprocket_edge_det u_edge_phi2 (
        .clk     (clk),
        .reset_n (reset_n),
        .level_i (sprocket_phi2),
        .rise_o  (w_phi2_rise)
    );

    // An edge is only accepted alone and in the state waiting for it; any
    // other edge (including a simultaneous phi1+phi2 pair) is a sequencing error.
    assign w_phi1_ok = w_phi1_rise && !w_phi2_rise &&
                       (state_q == ST_IDLE || state_q == ST_WAIT_PED);
    assign w_phi2_ok = w_phi2_rise && !w_phi1_rise && (state_q == ST_WAIT_SIG);
    assign w_seq_err = (w_phi1_rise || w_phi2_rise) && !(w_phi1_ok || w_phi2_ok);

    // adc_done outside a conversion state (e.g. a conversion orphaned by reset)
    // is dropped here.
    assign w_conv_done = adc_done && (state_q == ST_CONV_PED || state_q == ST_CONV_SIG);

    assign w_cnt_inc     = {1'b0, skip_cnt_q} + 1'b1;
    assign w_last_sample = (w_cnt_inc >= {1'b0, skip_max_q});

    // Signed accumulate; overflow when both operands share a sign the sum lacks.
    assign w_cds_ext = {{(ACC_WIDTH-CDS_W){cds_q[CDS_W-1]}}, cds_q};
    assign w_sum     = acc_q + w_cds_ext;
    assign w_ovf     = (acc_q[ACC_WIDTH-1] == w_cds_ext[ACC_WIDTH-1]) &&
                       (w_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
`ifdef CDS_SATURATE_EN
    assign w_acc_next = w_ovf ? (acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (w_phi1_ok)   state_d = ST_CONV_PED;
            ST_CONV_PED: if (adc_done)    state_d = ST_WAIT_SIG;
            ST_WAIT_SIG: if (w_phi2_ok)   state_d = ST_CONV_SIG;
            ST_CONV_SIG: if (adc_done)    state_d = ST_ACCUM;
            ST_ACCUM:    state_d = w_last_sample ? ST_EMIT : ST_WAIT_PED;
            ST_EMIT:     state_d = (pix_cnt_q == LAST_IDX) ? ST_IDLE : ST_WAIT_PED;
            ST_WAIT_PED: if (w_phi1_ok)   state_d = ST_CONV_PED;
            default:     state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        adc_start_d = w_phi1_ok || w_phi2_ok;
        eoc_d       = eoc_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_index_d = pix_index_q;
        status_d    = status_q;

        if (w_conv_done) begin
            eoc_d = 1'b1;
        end else if (w_phi1_rise || w_phi2_rise) begin
            eoc_d = 1'b0;
        end

        if (pix_valid_q && pix_ready) begin
            pix_valid_d = 1'b0;
        end

        if (state_q == ST_EMIT) begin
            pix_valid_d = 1'b1;
            pix_data_d  = acc_q;
            pix_index_d = pix_cnt_q;
            if (pix_valid_q && !pix_ready) begin
                status_d[STAT_OVERRUN] = 1'b1;
            end
        end

        if (w_seq_err) begin
            status_d[STAT_SEQ_ERR] = 1'b1;
        end
        if (state_q == ST_ACCUM && w_ovf) begin
            status_d[STAT_OVERFLOW] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_start_q <= 1'b0;
            eoc_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_index_q <= '0;
            status_q    <= '0;
        end else begin
            adc_start_q <= adc_start_d;
            eoc_q       <= eoc_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_index_q <= pix_index_d;
            status_q    <= status_d;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_q      <= '0;
            cds_q      <= '0;
            acc_q      <= '0;
            skip_cnt_q <= '0;
            skip_max_q <= '0;
            pix_cnt_q  <= '0;
        end else begin
            // skip_samples is captured once, on the first pedestal of a pixel.
            if (w_phi1_ok && skip_cnt_q == '0) begin
                skip_max_q <= (skip_samples == '0) ? SKIP_WIDTH'(1) : skip_samples;
            end
            case (state_q)
                ST_CONV_PED: if (adc_done) ped_q <= adc_data;
                ST_CONV_SIG: if (adc_done) cds_q <= {1'b0, ped_q} - {1'b0, adc_data};
                ST_ACCUM: begin
                    acc_q      <= w_acc_next;
                    skip_cnt_q <= skip_cnt_q + 1'b1;
                end
                ST_EMIT: begin
                    acc_q      <= '0;
                    skip_cnt_q <= '0;
                    pix_cnt_q  <= (pix_cnt_q == LAST_IDX) ? '0 : pix_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign adc_start    = adc_start_q;
    assign sprocket_eoc = eoc_q;
    assign pix_valid    = pix_valid_q;
    assign pix_data     = pix_data_q;
    assign pix_index    = pix_index_q;
    assign status       = status_q;

endmodule

`default_nettype wire

// File: tb/tb_sprocket_cds_accum.sv
// ============================================================================
// Module      : tb_sprocket_cds_accum
// Description : Self-checking bench for sprocket_cds_accum. Two instances
//               (ACC_WIDTH 24 and 14) share all inputs; expected pixel sums
//               for both widths come from an arithmetic model of the CDS
//               rules and are compared as pixels are accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprocket_cds_accum;

    localparam int PCS    = 16;
    localparam int ACCW_A = 24;
    localparam int ACCW_B = 14;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  skip_samples = '0;
    logic        phi1 = 1'b0;
    logic        phi2 = 1'b0;
    logic        adc_done = 1'b0;
    logic [11:0] adc_data = '0;
    logic        pix_ready = 1'b1;

    logic              eoc_a, start_a, valid_a, eoc_b, start_b, valid_b;
    logic [ACCW_A-1:0] data_a;
    logic [ACCW_B-1:0] data_b;
    logic [3:0]        index_a, index_b;
    logic [2:0]        status_a, status_b;

    sprocket_cds_accum u_dut_a (
        .clk(clk), .reset_n(reset_n), .skip_samples(skip_samples),
        .sprocket_phi1(phi1), .sprocket_phi2(phi2), .sprocket_eoc(eoc_a),
        .adc_start(start_a), .adc_done(adc_done), .adc_data(adc_data),
        .pix_data(data_a), .pix_index(index_a), .pix_valid(valid_a),
        .pix_ready(pix_ready), .status(status_a)
    );

    sprocket_cds_accum #(.ACC_WIDTH(ACCW_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .skip_samples(skip_samples),
        .sprocket_phi1(phi1), .sprocket_phi2(phi2), .sprocket_eoc(eoc_b),
        .adc_start(start_b), .adc_done(adc_done), .adc_data(adc_data),
        .pix_data(data_b), .pix_index(index_b), .pix_valid(valid_b),
        .pix_ready(pix_ready), .status(status_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        longint d_a;
        longint d_b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   starts_seen = 0;
    int   starts_exp = 0;
    bit   hold_ready_low = 1'b0;
    int   low_run = 0;

    // reference model state
    int     m_cnt = 0;
    int     m_skip = 1;
    int     m_idx = 0;
    longint m_acc_a = 0;
    longint m_acc_b = 0;
    bit     m_ovf_a = 1'b0;
    bit     m_ovf_b = 1'b0;
    bit     m_overrun = 1'b0;
    bit     m_seq = 1'b0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint acc_add(longint acc, longint cds, int w, inout bit ovf);
        longint maxv = (longint'(1) <<< (w - 1)) - 1;
        longint minv = -(longint'(1) <<< (w - 1));
        longint s = acc + cds;
        if (s > maxv || s < minv) begin
            ovf = 1'b1;
`ifdef CDS_SATURATE_EN
            s = (s > maxv) ? maxv : minv;
`else
            s = s & ((longint'(1) <<< w) - 1);
            if (s > maxv) s = s - (longint'(1) <<< w);
`endif
        end
        return s;
    endfunction

    function automatic void model_pair(int ped, int sig);
        if (m_cnt == 0) m_skip = (skip_samples == 0) ? 1 : int'(skip_samples);
        m_acc_a = acc_add(m_acc_a, longint'(ped - sig), ACCW_A, m_ovf_a);
        m_acc_b = acc_add(m_acc_b, longint'(ped - sig), ACCW_B, m_ovf_b);
        m_cnt++;
        if (m_cnt >= m_skip) begin
            sb.push_back('{m_idx, m_acc_a, m_acc_b});
            m_acc_a = 0;
            m_acc_b = 0;
            m_cnt   = 0;
            m_idx   = (m_idx + 1) % PCS;
        end
    endfunction

    // accepted-pixel monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && valid_a && pix_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel actual_index=%0d expected=none", index_a);
            end else begin
                e = sb.pop_front();
                check("pix_index_a", index_a, e.idx);
                check("pix_index_b", index_b, e.idx);
                check("pix_data_a", $signed(data_a), e.d_a);
                check("pix_data_b", $signed(data_b), e.d_b);
            end
        end
    end

    always @(negedge clk) begin
        if (start_a) starts_seen++;
    end

    // pix_ready: random, never low more than two cycles unless held
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready_low) pix_ready = 1'b0;
            else if (low_run >= 2) pix_ready = 1'b1;
            else pix_ready = 1'($urandom_range(0, 1));
            low_run = pix_ready ? 0 : low_run + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_start(string name);
        bit seen = 1'b0;
        starts_exp++;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (start_a) seen = 1'b1;
        end
        check({name, "_seen"}, seen, 1);
        check({name, "_eoc_clr"}, eoc_a, 0);
        @(negedge clk);
        check({name, "_width"}, start_a, 0);
    endtask

    task automatic adc_convert(int data, string name);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        adc_data = 12'(data);
        adc_done = 1'b1;
        @(posedge clk); #1;
        adc_done = 1'b0;
        @(negedge clk);
        check(name, eoc_a, 1);
    endtask

    // mode 1 injects a phi1 edge during the pedestal conversion and a
    // simultaneous phi1+phi2 edge while waiting for the signal strobe
    task automatic sample_pair(int ped, int sig, int mode);
        @(posedge clk); #1;
        phi1 = 1'b1;
        wait_start("ped_start");
        phi1 = 1'b0;
        if (mode == 1) begin
            @(posedge clk); #1;
            phi1 = 1'b1;
            m_seq = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            phi1 = 1'b0;
        end
        adc_convert(ped, "eoc_ped");
        if (mode == 1) begin
            @(posedge clk); #1;
            phi1 = 1'b1;
            phi2 = 1'b1;
            m_seq = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            phi1 = 1'b0;
            phi2 = 1'b0;
        end
        @(posedge clk); #1;
        phi2 = 1'b1;
        wait_start("sig_start");
        phi2 = 1'b0;
        adc_convert(sig, "eoc_sig");
        model_pair(ped, sig);
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check(name, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_status(string name);
        check({name, "_status_a"}, status_a, {m_ovf_a, m_overrun, m_seq});
        check({name, "_status_b"}, status_b, {m_ovf_b, m_overrun, m_seq});
    endtask

    task automatic check_zero(string name);
        check({name, "_valid"}, valid_a, 0);
        check({name, "_data_a"}, data_a, 0);
        check({name, "_data_b"}, data_b, 0);
        check({name, "_index"}, index_a, 0);
        check({name, "_start"}, start_a, 0);
        check({name, "_eoc"}, eoc_a, 0);
        check({name, "_status_a"}, status_a, 0);
        check({name, "_status_b"}, status_b, 0);
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // 16 pixels, 10 pairs each, cds = 100
        skip_samples = 10'd10;
        for (int p = 0; p < PCS; p++)
            for (int s = 0; s < 10; s++) sample_pair(2000, 1900, 0);
        drain("drain_cluster");
        check_status("cluster");

        // skip 0 behaves as 1; negative cds
        skip_samples = 10'd0;
        sample_pair(100, 300, 0);
        drain("drain_negative");

        // large positive sums: overflow on the 14-bit instance
        skip_samples = 10'd10;
        for (int s = 0; s < 10; s++) sample_pair(4095, 0, 0);
        drain("drain_overflow");
        check_status("overflow");

        // two pixels without acceptance: second overwrites the first
        skip_samples = 10'd0;
        hold_ready_low = 1'b1;
        @(posedge clk); #2;
        sample_pair(1234, 1000, 0);
        sample_pair(800, 1500, 0);
        m_overrun = 1'b1;
        repeat (4) @(negedge clk);
        check("overrun_valid", valid_a, 1);
        if (sb.size() == 2) begin
            check("overrun_index", index_a, sb[1].idx);
            check("overrun_data", $signed(data_a), sb[1].d_a);
            sb.delete(0);
        end else begin
            check("overrun_queue", sb.size(), 2);
        end
        check_status("overrun");
        hold_ready_low = 1'b0;
        drain("drain_overrun");

        // sequencing errors: phi2 while waiting for phi1, stray edges mid-pixel
        skip_samples = 10'd1;
        @(posedge clk); #1;
        phi2 = 1'b1;
        m_seq = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        phi2 = 1'b0;
        repeat (2) @(posedge clk);
        sample_pair(500, 123, 1);
        drain("drain_seqerr");
        check("seqerr_starts", starts_seen, starts_exp);
        check_status("seqerr");

        // randomized pairs, skip_samples changing between pairs
        for (int s = 0; s < 40; s++) begin
            skip_samples = 10'($urandom_range(0, 4));
            sample_pair(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 0);
        end
        guard = 0;
        while (m_cnt != 0 && guard < 10) begin
            sample_pair(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 0);
            guard++;
        end
        drain("drain_random");
        check("random_starts", starts_seen, starts_exp);
        check_status("random");

        // reset while the signal conversion is outstanding
        skip_samples = 10'd3;
        @(posedge clk); #1;
        phi1 = 1'b1;
        wait_start("rst_ped_start");
        phi1 = 1'b0;
        adc_convert(1000, "rst_eoc_ped");
        @(posedge clk); #1;
        phi2 = 1'b1;
        wait_start("rst_sig_start");
        phi2 = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midconv_reset");
        sb.delete();
        m_cnt = 0; m_idx = 0; m_acc_a = 0; m_acc_b = 0;
        m_ovf_a = 1'b0; m_ovf_b = 1'b0; m_overrun = 1'b0; m_seq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        adc_data = 12'd77;
        adc_done = 1'b1;
        @(posedge clk); #1;
        adc_done = 1'b0;
        repeat (2) @(negedge clk);
        check("late_done_eoc", eoc_a, 0);
        check("late_done_valid", valid_a, 0);
        check("late_done_starts", starts_seen, starts_exp);
        check_status("after_reset");
        skip_samples = 10'd1;
        sample_pair(300, 50, 0);
        drain("drain_after_reset");
        check("final_starts", starts_seen, starts_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
